// File: rtl/csr_issue_ctrl.sv
// ---------------------------------------------------------------------------
// csr_issue_ctrl
//
// Writeback-side initiator for the CSR register file. Takes one system
// instruction at a time from the WB stage, drives the CSR access port for
// exactly one EXEC cycle, returns the pre-write CSR value for register
// write-back and, for exceptions / ERTN / CSR writes, raises a one-cycle
// pipeline flush with a redirect PC followed by FLUSH_CYCLES cycles of
// blocked intake.
//
// Optional feature macro: CSR_ISSUE_INT_EN
//   defined   : has_int is sampled at accept into int_pend and an interrupt
//               outranks every other classification (ecode 0x00).
//   undefined : int_pend is tied to 0 and has_int is ignored.
//
// Handshake: an instruction transfers on a rising clk edge where
// ws_valid && ws_ready. ws_valid/ws_op/... may change freely while ws_ready
// is low; nothing is captured until a transfer happens.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   ws_valid / ws_ready        WB offer / accept
//   ws_op, ws_pc, ws_csr_num   instruction, PC, CSR index
//   ws_rd_value, ws_rj_value   write data, write mask (CSRXCHG)
//   ws_ex, ws_ecode, ws_esubcode  upstream exception and its codes
//   csr_re, csr_num, csr_rvalue   CSR read port
//   csr_we, csr_wmask, csr_wvalue CSR write port
//   wb_ex, wb_pc, wb_ecode, wb_esubcode  exception commit
//   ertn_flush                 return-from-exception commit
//   has_int, ex_entry, era     CSR status inputs
//   rd_valid, rd_value         old CSR value for the register file
//   flush_valid, flush_pc      pipeline flush and redirect target
//   dbg_state                  current FSM state (0 IDLE, 1 EXEC, 2 FLUSH)
// ---------------------------------------------------------------------------
module csr_issue_ctrl #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ws_valid,
    output logic        ws_ready,
    input  logic [2:0]  ws_op,
    input  logic [31:0] ws_pc,
    input  logic [13:0] ws_csr_num,
    input  logic [31:0] ws_rd_value,
    input  logic [31:0] ws_rj_value,
    input  logic        ws_ex,
    input  logic [5:0]  ws_ecode,
    input  logic [8:0]  ws_esubcode,
    output logic        csr_re,
    output logic [13:0] csr_num,
    input  logic [31:0] csr_rvalue,
    output logic        csr_we,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wvalue,
    output logic        wb_ex,
    output logic [31:0] wb_pc,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic        ertn_flush,
    input  logic        has_int,
    input  logic [31:0] ex_entry,
    input  logic [31:0] era,
    output logic        rd_valid,
    output logic [31:0] rd_value,
    output logic        flush_valid,
    output logic [31:0] flush_pc,
    output logic [1:0]  dbg_state
);

    localparam logic [2:0] OP_CSRRD   = 3'd1;
    localparam logic [2:0] OP_CSRWR   = 3'd2;
    localparam logic [2:0] OP_CSRXCHG = 3'd3;
    localparam logic [2:0] OP_ERTN    = 3'd4;
    localparam logic [2:0] OP_SYSCALL = 3'd5;
    localparam logic [2:0] OP_BREAK   = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  flush_cnt;
    logic        rd_pend;

    // Request register
    logic [2:0]  req_op;
    logic [31:0] req_pc;
    logic [13:0] req_num;
    logic [31:0] req_rd;
    logic [31:0] req_rj;
    logic        req_ex;
    logic [5:0]  req_ecode;
    logic [8:0]  req_esub;
    logic        int_pend;

    // EXEC decode
    logic        is_ex;
    logic        is_ertn;
    logic        is_rd;
    logic        is_wr;
    logic [5:0]  ex_code;
    logic [8:0]  ex_subcode;
    logic        exec_flush;
    logic        accept;

    always_comb begin
        is_ex      = 1'b0;
        is_ertn    = 1'b0;
        is_rd      = 1'b0;
        is_wr      = 1'b0;
        ex_code    = 6'h00;
        ex_subcode = 9'h000;
        if (state == S_EXEC) begin
            if (int_pend) begin
                is_ex = 1'b1;
            end else if (req_ex) begin
                is_ex      = 1'b1;
                ex_code    = req_ecode;
                ex_subcode = req_esub;
            end else begin
                case (req_op)
                    OP_SYSCALL: begin
                        is_ex   = 1'b1;
                        ex_code = 6'h0B;
                    end
                    OP_BREAK: begin
                        is_ex   = 1'b1;
                        ex_code = 6'h0C;
                    end
                    OP_ERTN:    is_ertn = 1'b1;
                    OP_CSRRD:   is_rd   = 1'b1;
                    OP_CSRWR, OP_CSRXCHG: begin
                        is_rd = 1'b1;
                        is_wr = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Every strobe is decoded only inside EXEC, so the exclusivity of
    // csr_we / wb_ex / ertn_flush follows from the priority chain above.
    assign csr_re      = is_rd;
    assign csr_num     = is_rd ? req_num : 14'h0000;
    assign csr_we      = is_wr;
    assign csr_wmask   = is_wr ? ((req_op == OP_CSRWR) ? 32'hFFFF_FFFF : req_rj) : 32'h0;
    assign csr_wvalue  = is_wr ? req_rd : 32'h0;
    assign wb_ex       = is_ex;
    assign wb_pc       = is_ex ? req_pc : 32'h0;
    assign wb_ecode    = ex_code;
    assign wb_esubcode = ex_subcode;
    assign ertn_flush  = is_ertn;

    assign exec_flush = is_ex | is_ertn | is_wr;
    assign ws_ready   = (state == S_IDLE) | ((state == S_EXEC) & ~exec_flush);
    assign accept     = ws_valid & ws_ready;
    assign dbg_state  = state;

`ifdef CSR_ISSUE_INT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            int_pend <= 1'b0;
        end else if (accept) begin
            int_pend <= has_int;
        end
    end
`else
    logic unused_has_int;
    assign unused_has_int = has_int;
    assign int_pend       = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            flush_cnt   <= 4'd0;
            rd_pend     <= 1'b0;
            rd_valid    <= 1'b0;
            rd_value    <= 32'h0;
            flush_valid <= 1'b0;
            flush_pc    <= 32'h0;
            req_op      <= 3'd0;
            req_pc      <= 32'h0;
            req_num     <= 14'h0;
            req_rd      <= 32'h0;
            req_rj      <= 32'h0;
            req_ex      <= 1'b0;
            req_ecode   <= 6'h0;
            req_esub    <= 9'h0;
        end else begin
            // A flushing CSR write captures its old value with the flush but
            // reports it one cycle later so rd_valid never coincides with
            // flush_valid.
            rd_valid    <= rd_pend;
            rd_pend     <= 1'b0;
            flush_valid <= 1'b0;

            case (state)
                S_EXEC: begin
                    if (is_rd) begin
                        rd_value <= csr_rvalue;
                    end
                    if (exec_flush) begin
                        rd_valid    <= 1'b0;
                        rd_pend     <= is_rd;
                        flush_valid <= 1'b1;
                        if (is_ex) begin
                            flush_pc <= ex_entry;
                        end else if (is_ertn) begin
                            flush_pc <= era;
                        end else begin
                            flush_pc <= req_pc + 32'd4;
                        end
                        flush_cnt <= 4'(FLUSH_CYCLES);
                        state     <= S_FLUSH;
                    end else begin
                        rd_valid <= is_rd;
                        state    <= S_IDLE;
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt == 4'd1) begin
                        flush_cnt <= 4'd0;
                        state     <= S_IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                default: ;
            endcase

            // ws_ready is low in FLUSH and in a flushing EXEC, so an accept
            // never collides with the flush branch above.
            if (accept) begin
                req_op    <= ws_op;
                req_pc    <= ws_pc;
                req_num   <= ws_csr_num;
                req_rd    <= ws_rd_value;
                req_rj    <= ws_rj_value;
                req_ex    <= ws_ex;
                req_ecode <= ws_ecode;
                req_esub  <= ws_esubcode;
                state     <= S_EXEC;
            end
        end
    end

endmodule

// File: tb/tb_csr_issue_ctrl.sv
`timescale 1ns/1ps
module tb_csr_issue_ctrl;

    localparam int FC = 2;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_XCHG = 3'd3;
    localparam logic [2:0] OP_ERTN = 3'd4;
    localparam logic [2:0] OP_SYS  = 3'd5;
    localparam logic [2:0] OP_BRK  = 3'd6;

    logic        clk = 1'b0;
    logic        reset;
    logic        ws_valid;
    logic        ws_ready;
    logic [2:0]  ws_op;
    logic [31:0] ws_pc;
    logic [13:0] ws_csr_num;
    logic [31:0] ws_rd_value;
    logic [31:0] ws_rj_value;
    logic        ws_ex;
    logic [5:0]  ws_ecode;
    logic [8:0]  ws_esubcode;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        wb_ex;
    logic [31:0] wb_pc;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic        ertn_flush;
    logic        has_int;
    logic [31:0] ex_entry;
    logic [31:0] era;
    logic        rd_valid;
    logic [31:0] rd_value;
    logic        flush_valid;
    logic [31:0] flush_pc;
    logic [1:0]  dbg_state;

    // Small CSR file model answering the read port
    logic [31:0] csr_mem [0:63];
    assign csr_rvalue = csr_mem[csr_num[5:0]];

    // Scoreboard
    logic [31:0] rd_exp_q[$];
    logic [31:0] flush_exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    csr_issue_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .reset(reset),
        .ws_valid(ws_valid), .ws_ready(ws_ready), .ws_op(ws_op), .ws_pc(ws_pc),
        .ws_csr_num(ws_csr_num), .ws_rd_value(ws_rd_value), .ws_rj_value(ws_rj_value),
        .ws_ex(ws_ex), .ws_ecode(ws_ecode), .ws_esubcode(ws_esubcode),
        .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
        .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .wb_ex(wb_ex), .wb_pc(wb_pc), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .ertn_flush(ertn_flush), .has_int(has_int), .ex_entry(ex_entry), .era(era),
        .rd_valid(rd_valid), .rd_value(rd_value),
        .flush_valid(flush_valid), .flush_pc(flush_pc), .dbg_state(dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    // Scoreboard monitor: pops expectations when the DUT reports a result
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (rd_valid || flush_valid) begin
                n_checks++;
                if (rd_valid && flush_valid)
                    $display("FAIL rd_flush_overlap rd_valid=%0d flush_valid=%0d required not both", rd_valid, flush_valid);
                else
                    n_pass++;
            end
            if (rd_valid === 1'b1) begin
                n_checks++;
                if (rd_exp_q.size() == 0) begin
                    $display("FAIL rd_unexpected rd_value=%h with no expected result", rd_value);
                end else begin
                    logic [31:0] e;
                    e = rd_exp_q.pop_front();
                    if (rd_value !== e) $display("FAIL rd_value got=%h exp=%h", rd_value, e);
                    else n_pass++;
                end
            end
            if (flush_valid === 1'b1) begin
                n_checks++;
                if (flush_exp_q.size() == 0) begin
                    $display("FAIL flush_unexpected flush_pc=%h with no expected flush", flush_pc);
                end else begin
                    logic [31:0] e;
                    e = flush_exp_q.pop_front();
                    if (flush_pc !== e) $display("FAIL flush_pc got=%h exp=%h", flush_pc, e);
                    else n_pass++;
                end
            end
        end
    end

    // Driver: offers one instruction and returns 1ns into the cycle after
    // the handshake (T+1), with ws_valid dropped.
    task automatic send(input logic [2:0] op, input logic [31:0] pc, input logic [13:0] num,
                        input logic [31:0] rd, input logic [31:0] rj, input logic ex,
                        input logic [5:0] ecode, input logic [8:0] esub);
        int waited;
        ws_valid = 1'b1; ws_op = op; ws_pc = pc; ws_csr_num = num;
        ws_rd_value = rd; ws_rj_value = rj; ws_ex = ex; ws_ecode = ecode; ws_esubcode = esub;
        waited = 0;
        @(negedge clk);
        while (ws_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (ws_ready !== 1'b1) begin
            n_checks++;
            $display("FAIL send_timeout ws_ready=%b after %0d cycles, required 1", ws_ready, waited);
        end
        @(posedge clk); #1;
        ws_valid = 1'b0; ws_ex = 1'b0;
    endtask

    task automatic settle();
        repeat (FC + 3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ws_valid = 0; ws_op = 0; ws_pc = 0; ws_csr_num = 0; ws_rd_value = 0; ws_rj_value = 0;
        ws_ex = 0; ws_ecode = 0; ws_esubcode = 0; has_int = 0; ex_entry = 0; era = 0;
        for (int i = 0; i < 64; i++) csr_mem[i] = $urandom;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (ws_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", ws_ready);
        else n_pass++;
        n_checks++;
        if ({csr_re, csr_we, wb_ex, ertn_flush, rd_valid, flush_valid} !== 6'b0)
            $display("FAIL reset_strobes got=%b exp=000000",
                     {csr_re, csr_we, wb_ex, ertn_flush, rd_valid, flush_valid});
        else n_pass++;
        n_checks++;
        if (rd_value !== 32'h0 || flush_pc !== 32'h0 || dbg_state !== 2'd0)
            $display("FAIL reset_values rd_value=%h flush_pc=%h state=%0d exp 0/0/0", rd_value, flush_pc, dbg_state);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_csrrd();
        csr_mem[5] = 32'h0000_0800;
        rd_exp_q.push_back(32'h0000_0800);
        send(OP_RD, 32'h1C00_0000, 14'h005, 32'h0, 32'h0, 1'b0, 6'h0, 9'h0);
        @(negedge clk);
        n_checks++;
        if (csr_re !== 1'b1 || csr_num !== 14'h005 || csr_we !== 1'b0 || ws_ready !== 1'b1)
            $display("FAIL csrrd_t1 re=%b num=%h we=%b ready=%b exp re=1 num=0005 we=0 ready=1",
                     csr_re, csr_num, csr_we, ws_ready);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (rd_valid !== 1'b1 || flush_valid !== 1'b0 || csr_re !== 1'b0)
            $display("FAIL csrrd_t2 rd_valid=%b flush_valid=%b re=%b exp 1/0/0", rd_valid, flush_valid, csr_re);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_csrxchg();
        csr_mem[6'h30] = 32'hCAFE_0001;
        rd_exp_q.push_back(32'hCAFE_0001);
        flush_exp_q.push_back(32'h1C00_0104);
        send(OP_XCHG, 32'h1C00_0100, 14'h030, 32'h1234_5678, 32'h0000_FFFF, 1'b0, 6'h0, 9'h0);
        @(negedge clk);
        n_checks++;
        if (csr_we !== 1'b1 || csr_re !== 1'b1 || csr_wmask !== 32'h0000_FFFF ||
            csr_wvalue !== 32'h1234_5678 || wb_ex !== 1'b0 || ws_ready !== 1'b0)
            $display("FAIL xchg_t1 we=%b re=%b wmask=%h wvalue=%h wb_ex=%b ready=%b exp 1/1/0000ffff/12345678/0/0",
                     csr_we, csr_re, csr_wmask, csr_wvalue, wb_ex, ws_ready);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (flush_valid !== 1'b1 || rd_value !== 32'hCAFE_0001 || ws_ready !== 1'b0 || csr_we !== 1'b0)
            $display("FAIL xchg_t2 flush_valid=%b rd_value=%h ready=%b we=%b exp 1/cafe0001/0/0",
                     flush_valid, rd_value, ws_ready, csr_we);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (rd_valid !== 1'b1 || flush_valid !== 1'b0 || ws_ready !== 1'b0)
            $display("FAIL xchg_t3 rd_valid=%b flush_valid=%b ready=%b exp 1/0/0", rd_valid, flush_valid, ws_ready);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (ws_ready !== 1'b1 || rd_valid !== 1'b0)
            $display("FAIL xchg_t4 ready=%b rd_valid=%b exp 1/0", ws_ready, rd_valid);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_exceptions();
        // SYSCALL
        ex_entry = 32'h1C00_8000;
        flush_exp_q.push_back(32'h1C00_8000);
        send(OP_SYS, 32'h1C00_0200, 14'h001, 32'h0, 32'h0, 1'b0, 6'h0, 9'h0);
        @(negedge clk);
        n_checks++;
        if (wb_ex !== 1'b1 || wb_ecode !== 6'h0B || wb_esubcode !== 9'h0 ||
            wb_pc !== 32'h1C00_0200 || csr_we !== 1'b0 || csr_re !== 1'b0)
            $display("FAIL syscall_t1 wb_ex=%b ecode=%h esub=%h wb_pc=%h we=%b re=%b exp 1/0b/000/1c000200/0/0",
                     wb_ex, wb_ecode, wb_esubcode, wb_pc, csr_we, csr_re);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (flush_valid !== 1'b1 || wb_ex !== 1'b0 || wb_pc !== 32'h0)
            $display("FAIL syscall_t2 flush_valid=%b wb_ex=%b wb_pc=%h exp 1/0/0", flush_valid, wb_ex, wb_pc);
        else n_pass++;
        @(posedge clk); #1;

        // BREAK
        flush_exp_q.push_back(32'h1C00_8000);
        send(OP_BRK, 32'h1C00_0300, 14'h002, 32'h0, 32'h0, 1'b0, 6'h0, 9'h0);
        @(negedge clk);
        n_checks++;
        if (wb_ex !== 1'b1 || wb_ecode !== 6'h0C || wb_pc !== 32'h1C00_0300)
            $display("FAIL break_t1 wb_ex=%b ecode=%h wb_pc=%h exp 1/0c/1c000300", wb_ex, wb_ecode, wb_pc);
        else n_pass++;
        @(posedge clk); #1;

        // Upstream exception on a CSRWR: the write is suppressed, no result
        ex_entry = 32'h1C00_9000;
        flush_exp_q.push_back(32'h1C00_9000);
        send(OP_WR, 32'h1C00_0310, 14'h004, 32'h5555_AAAA, 32'h0, 1'b1, 6'h08, 9'h001);
        @(negedge clk);
        n_checks++;
        if (wb_ex !== 1'b1 || wb_ecode !== 6'h08 || wb_esubcode !== 9'h001 ||
            csr_we !== 1'b0 || csr_re !== 1'b0 || wb_pc !== 32'h1C00_0310)
            $display("FAIL ws_ex_t1 wb_ex=%b ecode=%h esub=%h we=%b re=%b wb_pc=%h exp 1/08/001/0/0/1c000310",
                     wb_ex, wb_ecode, wb_esubcode, csr_we, csr_re, wb_pc);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_ertn();
        era = 32'h1C00_0204;
        flush_exp_q.push_back(32'h1C00_0204);
        send(OP_ERTN, 32'h1C00_0210, 14'h000, 32'h0, 32'h0, 1'b0, 6'h0, 9'h0);
        @(negedge clk);
        n_checks++;
        if (ertn_flush !== 1'b1 || wb_ex !== 1'b0 || csr_we !== 1'b0)
            $display("FAIL ertn_t1 ertn_flush=%b wb_ex=%b we=%b exp 1/0/0", ertn_flush, wb_ex, csr_we);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (ertn_flush !== 1'b0 || flush_valid !== 1'b1)
            $display("FAIL ertn_t2 ertn_flush=%b flush_valid=%b exp 0/1", ertn_flush, flush_valid);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_interrupt();
        ex_entry = 32'h1C00_8000;
`ifdef CSR_ISSUE_INT_EN
        flush_exp_q.push_back(32'h1C00_8000);
`else
        rd_exp_q.push_back(csr_mem[16]);
        flush_exp_q.push_back(32'h1C00_0404);
`endif
        has_int = 1'b1;
        send(OP_WR, 32'h1C00_0400, 14'h010, 32'hA5A5_A5A5, 32'h0, 1'b0, 6'h0, 9'h0);
        has_int = 1'b0;
        @(negedge clk);
        n_checks++;
`ifdef CSR_ISSUE_INT_EN
        if (wb_ex !== 1'b1 || wb_ecode !== 6'h00 || csr_we !== 1'b0 || wb_pc !== 32'h1C00_0400)
            $display("FAIL int_t1 wb_ex=%b ecode=%h we=%b wb_pc=%h exp 1/00/0/1c000400", wb_ex, wb_ecode, csr_we, wb_pc);
        else n_pass++;
`else
        if (wb_ex !== 1'b0 || csr_we !== 1'b1 || csr_wmask !== 32'hFFFF_FFFF || csr_wvalue !== 32'hA5A5_A5A5)
            $display("FAIL int_t1 wb_ex=%b we=%b wmask=%h wvalue=%h exp 0/1/ffffffff/a5a5a5a5",
                     wb_ex, csr_we, csr_wmask, csr_wvalue);
        else n_pass++;
`endif
        // has_int rising after accept must not affect the in-flight read
        rd_exp_q.push_back(csr_mem[9]);
        send(OP_RD, 32'h1C00_0410, 14'h009, 32'h0, 32'h0, 1'b0, 6'h0, 9'h0);
        has_int = 1'b1;
        @(negedge clk);
        n_checks++;
        if (wb_ex !== 1'b0 || csr_re !== 1'b1 || csr_num !== 14'h009)
            $display("FAIL int_late_t1 wb_ex=%b re=%b num=%h exp 0/1/0009", wb_ex, csr_re, csr_num);
        else n_pass++;
        @(posedge clk); #1;
        has_int = 1'b0;
    endtask

    task automatic test_pc_wrap();
        rd_exp_q.push_back(csr_mem[17]);
        flush_exp_q.push_back(32'h0000_0000);
        send(OP_WR, 32'hFFFF_FFFC, 14'h011, 32'h0BAD_F00D, 32'h1234_0000, 1'b0, 6'h0, 9'h0);
        @(negedge clk);
        n_checks++;
        if (csr_we !== 1'b1 || csr_wmask !== 32'hFFFF_FFFF || csr_wvalue !== 32'h0BAD_F00D)
            $display("FAIL wrap_t1 we=%b wmask=%h wvalue=%h exp 1/ffffffff/0badf00d", csr_we, csr_wmask, csr_wvalue);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [13:0] num;
        logic [13:0] prev_num;
        settle();
        prev_num = 14'h0;
        for (int i = 0; i < 8; i++) begin
            num = 14'($urandom_range(0, 63));
            rd_exp_q.push_back(csr_mem[num[5:0]]);
            ws_valid = 1'b1; ws_op = OP_RD; ws_csr_num = num; ws_pc = 32'h1C00_1000 + 32'(i * 4);
            @(negedge clk);
            n_checks++;
            if (ws_ready !== 1'b1) $display("FAIL b2b_ready op=%0d got=%b exp=1", i, ws_ready);
            else n_pass++;
            if (i > 0) begin
                n_checks++;
                if (csr_re !== 1'b1 || csr_num !== prev_num)
                    $display("FAIL b2b_read op=%0d re=%b num=%h exp re=1 num=%h", i - 1, csr_re, csr_num, prev_num);
                else n_pass++;
            end
            prev_num = num;
            @(posedge clk); #1;
        end
        ws_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (csr_re !== 1'b1 || csr_num !== prev_num)
            $display("FAIL b2b_last re=%b num=%h exp re=1 num=%h", csr_re, csr_num, prev_num);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        int acc_cycle;
        settle();
        csr_mem[7] = 32'h7777_0007;
        rd_exp_q.push_back(csr_mem[18]);
        flush_exp_q.push_back(32'h1C00_0504);
        rd_exp_q.push_back(32'h7777_0007);
        send(OP_WR, 32'h1C00_0500, 14'h012, 32'h1, 32'h0, 1'b0, 6'h0, 9'h0);
        // Offer changing instructions while ws_ready is low
        ws_valid = 1'b1; ws_op = OP_SYS; ws_pc = 32'hDEAD_0000;
        acc_cycle = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (ws_ready === 1'b1) begin
                acc_cycle = c;
                break;
            end
            n_checks++;
            if (wb_ex !== 1'b0) $display("FAIL stall_no_ex cycle=%0d wb_ex=%b exp=0", c, wb_ex);
            else n_pass++;
            @(posedge clk); #1;
            if (c == 1) begin
                ws_op = OP_BRK; ws_ex = 1'b1; ws_ecode = 6'h3F;
            end else begin
                ws_op = OP_RD; ws_ex = 1'b0; ws_csr_num = 14'h007;
            end
        end
        n_checks++;
        if (acc_cycle !== FC + 2) $display("FAIL stall_accept_cycle got=%0d exp=%0d", acc_cycle, FC + 2);
        else n_pass++;
        @(posedge clk); #1;
        ws_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (csr_re !== 1'b1 || csr_num !== 14'h007 || wb_ex !== 1'b0)
            $display("FAIL stall_t1 re=%b num=%h wb_ex=%b exp 1/0007/0", csr_re, csr_num, wb_ex);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        settle();
        ex_entry = 32'h1C00_8000;
        send(OP_SYS, 32'h1C00_0600, 14'h000, 32'h0, 32'h0, 1'b0, 6'h0, 9'h0);
        n_checks++;
        if (wb_ex !== 1'b1) $display("FAIL rstmid_before wb_ex=%b exp=1", wb_ex);
        else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (wb_ex !== 1'b0 || ws_ready !== 1'b1 || dbg_state !== 2'd0)
            $display("FAIL rstmid_async wb_ex=%b ready=%b state=%0d exp 0/1/0", wb_ex, ws_ready, dbg_state);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < FC + 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (flush_valid !== 1'b0 || ws_ready !== 1'b1 || wb_ex !== 1'b0)
                $display("FAIL rstmid_after cycle=%0d flush_valid=%b ready=%b wb_ex=%b exp 0/1/0",
                         c, flush_valid, ws_ready, wb_ex);
            else n_pass++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_csrrd();
        test_csrxchg();
        test_exceptions();
        test_ertn();
        test_interrupt();
        test_pc_wrap();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        settle();
        n_checks++;
        if (rd_exp_q.size() != 0 || flush_exp_q.size() != 0)
            $display("FAIL scoreboard_drain rd_left=%0d flush_left=%0d exp 0/0", rd_exp_q.size(), flush_exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
